pla_fsm_unit: RTL
=================

Name: pla_fsm_unit

Overview:
- Parametrised, field-programmable sum-of-products state machine cell; next generation of the fixed two-term AND-OR cell in the logic fabric.
- N_TERM programmable product terms over primary inputs and fed-back state; programmable OR plane drives registered next-state bits and registered outputs.
- Configuration is loaded through a serial scan chain; cfg_out allows daisy-chaining units.
- A combinational cascade input is ORed into the outputs, so units can be chained like the fixed cell's OR input.

Parameters:
- N_IN, 4, primary input literals
- N_ST, 2, state register bits
- N_OUT, 2, output bits
- N_TERM, 8, product terms
- Derived, not overridable: L = N_IN+N_ST; W = N_ST+N_OUT; A = N_TERM*2*L (AND-plane bits); CFG_BITS = A + N_TERM*W. Defaults give 96 + 32 = 128.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- cfg_en  in  1  shift one configuration bit this cycle
- cfg_data  in  1  serial configuration bit
- cfg_out  out  1  cfg_reg[0], for daisy-chaining
- cfg_valid  out  1  exactly CFG_BITS bits have been shifted since the last load start
- step  in  1  advance the FSM one transition
- st_clr  in  1  synchronous clear of state only
- in  in  N_IN  primary inputs
- cas_in  in  N_OUT  cascade OR input
- state  out  N_ST  current state register
- out  out  N_OUT  out_reg | cas_in

Behaviour:
- Reset: cfg_reg=0, cfg_cnt=0, cfg_valid=0, state=0, out_reg=0, so out = cas_in. rst overrides all other inputs.
- Literal vector x = {state, in}; x[j] for j<N_IN is in[j], otherwise state[j-N_IN].
- Term t config field tc = cfg_reg[t*2L +: 2L].
  - term[t] = AND over j of (~tc[2j] | x[j]) & (~tc[2j+1] | ~x[j]).
  - Neither bit set: don't-care literal. Both bits set: the term is constant 0.
  - An all-zero field gives constant 1.
- OR plane: oc_t = cfg_reg[A + t*W +: W]; sum = OR over t of (term[t] ? oc_t : 0).
  - ns = sum[N_ST-1:0]; no = sum[W-1:N_ST]. Combinational from the current state and in.
- Config shift when cfg_en=1: cfg_reg <= {cfg_data, cfg_reg[CFG_BITS-1:1]}. The first bit shifted ends at bit 0 after CFG_BITS shifts.
- cfg_cnt (clog2(CFG_BITS+1) bits):
  - Increments on each cfg_en while below CFG_BITS.
  - If cfg_en=1 while cfg_valid=1, a new load starts: cfg_cnt <= 1.
  - Extra shifts past CFG_BITS without the valid flag set cannot occur by construction.
  - cfg_valid = (cfg_cnt == CFG_BITS), registered.
- Priority per cycle:
  1. rst
  2. cfg_en: state and out_reg hold; step is ignored
  3. st_clr: state <= 0; out_reg holds
  4. step && cfg_valid: state <= ns and out_reg <= no, both computed from pre-edge values
  5. otherwise hold
- step while cfg_valid=0 is ignored and has no effect.
- Latency: one cycle from step to updated state/out. The cascade path is combinational with zero latency.
- Reset mid-load discards the partial config: cfg_reg is cleared and cfg_valid=0.

Decomposition:
- Package pla_fsm_pkg:
  - Functions cfg_bits(N_IN,N_ST,N_OUT,N_TERM), and_base(t), or_base(t)
  - Literal-encoding constants LIT_TRUE=0, LIT_COMP=1
- Sub-module pla_term: one product term (inputs x[L-1:0] and tc[2L-1:0]; output term), instantiated N_TERM times via generate.

Test Plan:
- Reset: hold rst 2 cycles with cas_in=2'b10 -> state=0, out=2'b10, cfg_valid=0, cfg_out=0. Pulse step -> no change.
- Partial load: shift 127 bits -> cfg_valid=0 and step is ignored. The 128th shift -> cfg_valid=1 next cycle. A 129th shift -> cfg_valid=0 with cfg_cnt=1.
- Toggle machine:
  - Config: term0 = in0 & ~s0 -> ns0; term1 = ~in0 & s0 -> ns0; term2 = s0 -> out0. All other fields zero except terms 3-7, whose AND fields are set to constant 0.
  - in0=1 with 4 steps -> state[0] goes 1,0,1,0 and out[0] lags state by one step.
  - in0=0 -> state holds.
- Priority: assert step with cfg_en=1 -> state holds. st_clr with step -> state=0.
- Chaining: two units with u0.cfg_out driving u1.cfg_data, 256 shifts -> both cfg_valid=1. u1 out0 equals u1 logic | u0 out via cas_in, with zero-cycle cascade latency.
- rst asserted at shift 60 -> cfg_valid=0 and cfg_reg=0; a full 128-bit reload then succeeds.

Source files
------------

// File: rtl/pla_fsm_pkg.sv
// Shared constants, sizing helpers and per-cycle action encoding for the
// programmable sum-of-products state machine cell.
package pla_fsm_pkg;

    // Position of each literal's select bit inside a 2-bit AND-plane field
    localparam int LIT_TRUE = 0;
    localparam int LIT_COMP = 1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CFG,
        OP_CLR,
        OP_STEP
    } op_e;

    function automatic int cfg_bits(input int n_in, input int n_st,
                                    input int n_out, input int n_term);
        return n_term * 2 * (n_in + n_st) + n_term * (n_st + n_out);
    endfunction

    function automatic int and_base(input int t, input int l);
        return t * 2 * l;
    endfunction

    function automatic int or_base(input int t, input int a, input int w);
        return a + t * w;
    endfunction

endpackage

// File: rtl/pla_term.sv
// One programmable product term: every literal can be required true,
// required false, ignored, or (both selects set) force the term to zero.
module pla_term
    import pla_fsm_pkg::*;
#(
    parameter int L = 6
) (
    input  logic [L-1:0]   x,
    input  logic [2*L-1:0] tc,
    output logic           term
);

    always_comb begin
        term = 1'b1;
        for (int j = 0; j < L; j++) begin
            term &= (~tc[2*j+LIT_TRUE] | x[j]) & (~tc[2*j+LIT_COMP] | ~x[j]);
        end
    end

endmodule

// File: rtl/pla_fsm_unit.sv
// Field-programmable PLA state machine cell with a serial config scan chain
// and a combinational cascade OR input for building wider functions.
module pla_fsm_unit
    import pla_fsm_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_ST   = 2,
    parameter int N_OUT  = 2,
    parameter int N_TERM = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_data,
    output logic             cfg_out,
    output logic             cfg_valid,
    input  logic             step,
    input  logic             st_clr,
    input  logic [N_IN-1:0]  in,
    input  logic [N_OUT-1:0] cas_in,
    output logic [N_ST-1:0]  state,
    output logic [N_OUT-1:0] out
);

    localparam int L        = N_IN + N_ST;
    localparam int W        = N_ST + N_OUT;
    localparam int A        = N_TERM * 2 * L;
    localparam int CFG_BITS = cfg_bits(N_IN, N_ST, N_OUT, N_TERM);
    localparam int CW       = $clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] cfg_reg, cfg_nxt;
    logic [CW-1:0]       cfg_cnt, cnt_nxt;
    logic                valid_nxt;
    logic [N_OUT-1:0]    out_reg, out_nxt;
    logic [N_ST-1:0]     state_nxt;
    logic [L-1:0]        x;
    logic [N_TERM-1:0]   term;
    logic [W-1:0]        sum;
    op_e                 op;

    assign x = {state, in};

    for (genvar t = 0; t < N_TERM; t++) begin : g_term
        pla_term #(.L(L)) u_term (
            .x    (x),
            .tc   (cfg_reg[and_base(t, L) +: 2*L]),
            .term (term[t])
        );
    end

    always_comb begin
        sum = '0;
        for (int t = 0; t < N_TERM; t++) begin
            if (term[t]) sum |= cfg_reg[or_base(t, A, W) +: W];
        end
    end

    // Loading always wins over stepping so a half-written plane never runs
    always_comb begin
        op = OP_HOLD;
        if (cfg_en)                  op = OP_CFG;
        else if (st_clr)             op = OP_CLR;
        else if (step && cfg_valid)  op = OP_STEP;
    end

    always_comb begin
        cfg_nxt   = cfg_reg;
        cnt_nxt   = cfg_cnt;
        state_nxt = state;
        out_nxt   = out_reg;
        case (op)
            OP_CFG: begin
                cfg_nxt = {cfg_data, cfg_reg[CFG_BITS-1:1]};
                if (cfg_valid)                   cnt_nxt = CW'(1);
                else if (cfg_cnt < CW'(CFG_BITS)) cnt_nxt = cfg_cnt + CW'(1);
            end
            OP_CLR:  state_nxt = '0;
            OP_STEP: begin
                state_nxt = sum[N_ST-1:0];
                out_nxt   = sum[W-1:N_ST];
            end
            default: ;
        endcase
        valid_nxt = (cnt_nxt == CW'(CFG_BITS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_reg   <= '0;
            cfg_cnt   <= '0;
            cfg_valid <= 1'b0;
            state     <= '0;
            out_reg   <= '0;
        end else begin
            cfg_reg   <= cfg_nxt;
            cfg_cnt   <= cnt_nxt;
            cfg_valid <= valid_nxt;
            state     <= state_nxt;
            out_reg   <= out_nxt;
        end
    end

    assign cfg_out = cfg_reg[0];
    assign out     = out_reg | cas_in;

endmodule
